// File: rtl/regcheck_pkg.sv
// Shared types and constants for the register self-check sequencer.
// The *_DEF values are the default build widths; check_entry_t describes one
// check-table entry at those default widths.
package regcheck_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int REG_AW_DEF     = 5;
   localparam int NUM_CHECKS_DEF = 8;
   localparam int IDX_W          = $clog2(NUM_CHECKS_DEF);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   typedef struct packed {
      logic [REG_AW_DEF-1:0] reg_num;
      logic [DATA_W_DEF-1:0] val;
      logic                  valid;
   } check_entry_t;

endpackage

// File: rtl/regcheck_table.sv
// Check-table storage: (register, expected value, valid) per entry.
// The read is asynchronous so the sequencer can decide skip-or-issue for an
// entry in the same cycle it selects it; the table is small register storage.
module regcheck_table #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int NUM_CHECKS = 8,
   parameter int IW         = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              clr,
   input  logic [IW-1:0]     wr_idx,
   input  logic [REG_AW-1:0] wr_reg,
   input  logic [DATA_W-1:0] wr_val,
   input  logic [IW-1:0]     rd_idx,
   output logic [REG_AW-1:0] rd_reg,
   output logic [DATA_W-1:0] rd_val,
   output logic              rd_valid
);

   logic [NUM_CHECKS-1:0] valid_reg;
   logic [REG_AW-1:0]     reg_mem [NUM_CHECKS];
   logic [DATA_W-1:0]     val_mem [NUM_CHECKS];

   // Valid bits: cleared by reset or clr (clr beats a same-cycle write).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_reg <= '0;
      end else if (clr) begin
         valid_reg <= '0;
      end else if (wr_en) begin
         valid_reg[wr_idx] <= 1'b1;
      end
   end

   // Entry payload; only meaningful while the matching valid bit is set.
   always_ff @(posedge clock) begin
      if (wr_en && !clr) begin
         reg_mem[wr_idx] <= wr_reg;
         val_mem[wr_idx] <= wr_val;
      end
   end

   assign rd_reg   = reg_mem[rd_idx];
   assign rd_val   = val_mem[rd_idx];
   assign rd_valid = valid_reg[rd_idx];

endmodule

// File: rtl/regfile_check_sequencer.sv
// Register-file self-check sequencer: waits run_cycles+1 cycles after start,
// then reads every valid table entry through the regfile debug port and
// counts mismatches, capturing the first failure.
// Optional: define REGFILE_CHECK_FAILMAP_EN to build the per-entry fail_map.
import regcheck_pkg::*;

module regfile_check_sequencer #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int NUM_CHECKS = 8,
   parameter int CNT_W      = 16,
   parameter int READ_LAT   = 1,
   localparam int IW        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int EW        = $clog2(NUM_CHECKS + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      run_cycles,
   input  logic                  cfg_we,
   input  logic [IW-1:0]         cfg_idx,
   input  logic [REG_AW-1:0]     cfg_reg,
   input  logic [DATA_W-1:0]     cfg_val,
   input  logic                  cfg_clr,
   output logic [REG_AW-1:0]     dbg_rd_addr,
   input  logic [DATA_W-1:0]     dbg_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [EW-1:0]         error_count,
   output logic                  fail_valid,
   output logic [REG_AW-1:0]     fail_reg,
   output logic [DATA_W-1:0]     fail_exp,
   output logic [DATA_W-1:0]     fail_got,
   output logic [NUM_CHECKS-1:0] fail_map
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHECKS - 1);
   // Cycle index inside COMPARE on which the read data is valid.
   localparam logic [1:0]    LAT_LAST = (READ_LAT == 0) ? 2'd0 : 2'(READ_LAT - 1);

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [IW-1:0]     idx_reg;
   logic [1:0]        lat_reg;
   logic [EW-1:0]     err_reg;
   logic              fail_valid_reg;
   logic [REG_AW-1:0] fail_reg_reg;
   logic [DATA_W-1:0] fail_exp_reg;
   logic [DATA_W-1:0] fail_got_reg;

   logic              cfg_ok;
   logic              start_ok;
   logic [REG_AW-1:0] tbl_reg;
   logic [DATA_W-1:0] tbl_val;
   logic              tbl_valid;
   logic              cmp_now;
   logic              mismatch;

   assign cfg_ok   = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
   assign start_ok = start && cfg_ok;

   regcheck_table #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .NUM_CHECKS (NUM_CHECKS),
      .IW         (IW)
   ) u_table (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (cfg_we && cfg_ok),
      .clr      (cfg_clr && cfg_ok),
      .wr_idx   (cfg_idx),
      .wr_reg   (cfg_reg),
      .wr_val   (cfg_val),
      .rd_idx   (idx_reg),
      .rd_reg   (tbl_reg),
      .rd_val   (tbl_val),
      .rd_valid (tbl_valid)
   );

   // Pick the cycle on which dbg_rd_data is sampled: ISSUE for a combinational
   // regfile port, otherwise the last COMPARE cycle.
   always_comb begin
      cmp_now = 1'b0;
      if (READ_LAT == 0) begin
         cmp_now = (state_reg == ST_ISSUE) && tbl_valid;
      end else begin
         cmp_now = (state_reg == ST_COMPARE) && (lat_reg == LAT_LAST);
      end
      mismatch = cmp_now && (dbg_rd_data != tbl_val);
   end

   // Sequencer FSM plus error counting and first-failure capture.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         lat_reg        <= '0;
         err_reg        <= '0;
         fail_valid_reg <= 1'b0;
         fail_reg_reg   <= '0;
         fail_exp_reg   <= '0;
         fail_got_reg   <= '0;
      end else begin
         if (mismatch) begin
            err_reg <= err_reg + 1'b1;
            if (!fail_valid_reg) begin
               fail_valid_reg <= 1'b1;
               fail_reg_reg   <= tbl_reg;
               fail_exp_reg   <= tbl_val;
               fail_got_reg   <= dbg_rd_data;
            end
         end
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  err_reg        <= '0;
                  fail_valid_reg <= 1'b0;
                  fail_reg_reg   <= '0;
                  fail_exp_reg   <= '0;
                  fail_got_reg   <= '0;
                  cnt_reg        <= run_cycles;
                  idx_reg        <= '0;
                  state_reg      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_reg == '0) begin
                  idx_reg   <= '0;
                  state_reg <= ST_ISSUE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_ISSUE: begin
               lat_reg <= '0;
               if (tbl_valid) begin
                  state_reg <= ST_COMPARE;
               end else if (idx_reg == LAST_IDX) begin
                  state_reg <= ST_DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            ST_COMPARE: begin
               if (lat_reg == LAT_LAST) begin
                  if (idx_reg == LAST_IDX) begin
                     state_reg <= ST_DONE;
                  end else begin
                     idx_reg   <= idx_reg + 1'b1;
                     state_reg <= ST_ISSUE;
                  end
               end else begin
                  lat_reg <= lat_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef REGFILE_CHECK_FAILMAP_EN
   logic [NUM_CHECKS-1:0] fail_map_reg;

   // Per-entry fail bits, cleared when a new run starts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fail_map_reg <= '0;
      end else if (start_ok) begin
         fail_map_reg <= '0;
      end else if (mismatch) begin
         fail_map_reg[idx_reg] <= 1'b1;
      end
   end

   assign fail_map = fail_map_reg;
`else
   assign fail_map = '0;
`endif

   // The address is held on the selected entry through ISSUE and COMPARE.
   assign dbg_rd_addr = ((state_reg == ST_ISSUE) || (state_reg == ST_COMPARE)) ? tbl_reg : '0;
   assign busy        = (state_reg == ST_WAIT) || (state_reg == ST_ISSUE) ||
                        (state_reg == ST_COMPARE);
   assign done        = (state_reg == ST_DONE);
   assign pass        = done && (err_reg == '0);
   assign error_count = err_reg;
   assign fail_valid  = fail_valid_reg;
   assign fail_reg    = fail_reg_reg;
   assign fail_exp    = fail_exp_reg;
   assign fail_got    = fail_got_reg;

endmodule
